// File: rtl/muldiv_seq_if.sv
// Request/response bundle for the sequential multiply/divide unit.
// The master drives requests; the slave returns status and the HI/LO registers.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, flush,
                  input  busy, done, div_by_zero, hi, lo);
  modport slave  (input  start, op, a, b, flush,
                  output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/muldiv_seq.sv
// Iterative MIPS-style multiply/divide unit: one shift-add or restoring-divide
// step per cycle on operand magnitudes, sign fix-up in a final cycle.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  muldiv_seq_if.slave mds
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // product high half, or partial remainder
  logic [WIDTH-1:0] q_q, q_d;       // multiplier being consumed, or dividend -> quotient
  logic [WIDTH-1:0] m_q, m_d;       // multiplicand or divisor magnitude
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             neg_a, neg_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] prod_fix;

  // op[0] clear selects the signed variants of both MULT and DIV
  assign neg_a = ~mds.op[0] & mds.a[WIDTH-1];
  assign neg_b = ~mds.op[0] & mds.b[WIDTH-1];
  assign abs_a = neg_a ? -mds.a : mds.a;
  assign abs_b = neg_b ? -mds.b : mds.b;

  assign mul_sum  = {1'b0, acc_q} + {1'b0, (q_q[0] ? m_q : {WIDTH{1'b0}})};
  assign div_sh   = {acc_q, q_q[WIDTH-1]};
  assign div_ge   = div_sh >= {1'b0, m_q};
  assign product  = {acc_q, q_q};
  assign prod_fix = neg_res_q ? -product : product;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    q_d       = q_q;
    m_d       = m_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (mds.start && !mds.flush) begin
          case (mds.op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              state_d   = RUN;
              cnt_d     = '0;
              acc_d     = '0;
              is_div_d  = mds.op[1];
              q_d       = mds.op[1] ? abs_a : abs_b;
              m_d       = mds.op[1] ? abs_b : abs_a;
              neg_res_d = neg_a ^ neg_b;
              neg_rem_d = neg_a;
              dbz_d     = mds.op[1] & (mds.b == '0);
            end
            OP_MTHI: hi_d = mds.a;
            OP_MTLO: lo_d = mds.a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (mds.flush) begin
          state_d = IDLE;
        end else begin
          if (is_div_q) begin
            acc_d = div_ge ? WIDTH'(div_sh - {1'b0, m_q}) : div_sh[WIDTH-1:0];
            q_d   = {q_q[WIDTH-2:0], div_ge};
          end else begin
            acc_d = mul_sum[WIDTH:1];
            q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = FIX;
        end
      end
      FIX: begin
        if (mds.flush) begin
          state_d = IDLE;
        end else begin
          // A zero divisor leaves |a| as remainder; sign fix-up turns it back into a
          if (is_div_q) begin
            lo_d = dbz_q ? {WIDTH{1'b1}} : (neg_res_q ? -q_q : q_q);
            hi_d = neg_rem_q ? -acc_q : acc_q;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      m_q       <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      m_q       <= m_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign mds.busy        = (state_q != IDLE);
  assign mds.done        = (state_q == DONE);
  assign mds.div_by_zero = (state_q == DONE) & dbz_q;
  assign mds.hi          = hi_q;
  assign mds.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: issued ops push expected results, an
// independent monitor pops and compares on every done pulse.
module tb_muldiv_seq;
  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_seq_if #(.WIDTH(W)) bus ();
  muldiv_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .mds(bus));

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    logic [2:0]   op;
    int           cyc;
  } exp_t;

  exp_t         exp_q[$];
  int           n_vec = 0;
  int           n_miss = 0;
  int           cyc = 0;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural definition
  function automatic void ref_model(input logic [2:0] o, input logic [W-1:0] av,
                                    input logic [W-1:0] bv, output logic [W-1:0] h,
                                    output logic [W-1:0] l, output logic z);
    logic [2*W-1:0] p;
    int sa, sb;
    h = '0; l = '0; z = 1'b0; p = '0;
    sa = $signed(av);
    sb = $signed(bv);
    case (o)
      3'd0: begin
        p = 64'(longint'(sa) * longint'(sb));
        h = p[2*W-1:W]; l = p[W-1:0];
      end
      3'd1: begin
        p = {32'b0, av} * {32'b0, bv};
        h = p[2*W-1:W]; l = p[W-1:0];
      end
      3'd2, 3'd3: begin
        if (bv == '0) begin
          l = '1; h = av; z = 1'b1;
        end else if (o == 3'd2) begin
          if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
            l = av; h = '0;
          end else begin
            l = sa / sb; h = sa % sb;
          end
        end else begin
          l = av / bv; h = av % bv;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic fl, output exp_t e);
    logic [W-1:0] h, l;
    logic z;
    bus.start = 1'b1; bus.op = o; bus.a = av; bus.b = bv; bus.flush = fl;
    ref_model(o, av, bv, h, l, z);
    e.hi = h; e.lo = l; e.dbz = z; e.op = o; e.cyc = cyc;
    if (!fl) begin
      if (o <= 3'd3) exp_q.push_back(e);
      else if (o == 3'd4) model_hi = av;
      else if (o == 3'd5) model_lo = av;
    end
  endtask

  // Issue one arithmetic op; optionally hammer start while busy, and
  // optionally raise flush at cycle T+fl_k
  task automatic run_arith(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input bit noise, input int fl_k);
    exp_t e;
    drive(o, av, bv, 1'b0, e);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      chk("busy_during_op", bus.busy, 1);
      bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.op    = 3'($urandom_range(0, 7));
      bus.a     = $urandom;
      bus.b     = $urandom;
      bus.flush = (k == fl_k);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("busy_after_done", bus.busy, 0);
    chk("hi_held", bus.hi, e.hi);
    chk("lo_held", bus.lo, e.lo);
    model_hi = e.hi;
    model_lo = e.lo;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", bus.done, 0);
        end else begin
          e = exp_q.pop_front();
          chk("lo", bus.lo, e.lo);
          chk("hi", bus.hi, e.hi);
          chk("div_by_zero", bus.div_by_zero, e.dbz);
          chk("done_latency", cyc, e.cyc + LAT);
          $display("txn op=%0d hi=%h lo=%h dbz=%0b at cycle %0d", e.op, bus.hi, bus.lo,
                   bus.div_by_zero, cyc);
        end
      end else if (bus.div_by_zero !== 1'b0) begin
        chk("dbz_without_done", bus.div_by_zero, 0);
      end
    end
  end

  initial begin
    exp_t e;
    int sel;
    logic [W-1:0] av, bv;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dbz", bus.div_by_zero, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    rst = 1'b0;

    run_arith(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, 0);
    run_arith(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 0);
    run_arith(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    run_arith(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    run_arith(3'd3, 32'd7, 32'd0, 1'b0, 0);

    drive(3'd4, 32'h1234, 32'd0, 1'b0, e);
    @(negedge clk);
    chk("mthi_busy", bus.busy, 0);
    chk("mthi_hi", bus.hi, 32'h1234);
    drive(3'd5, 32'h5678, 32'd0, 1'b0, e);
    @(negedge clk);
    bus.start = 1'b0;
    chk("mtlo_busy", bus.busy, 0);
    chk("mtlo_hi", bus.hi, 32'h1234);
    chk("mtlo_lo", bus.lo, 32'h5678);

    for (int r = 6; r <= 7; r++) begin
      drive(3'(r), $urandom, $urandom, 1'b0, e);
      @(negedge clk);
      bus.start = 1'b0;
      chk("reserved_busy", bus.busy, 0);
      chk("reserved_hi", bus.hi, model_hi);
      chk("reserved_lo", bus.lo, model_lo);
    end

    drive(3'd4, 32'hDEAD_BEEF, 32'd0, 1'b1, e);
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush_idle_busy", bus.busy, 0);
    chk("flush_idle_hi", bus.hi, 32'h1234);

    drive(3'd0, $urandom, $urandom, 1'b0, e);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      chk("flush_run_busy", bus.busy, 1);
      if (k == 10) bus.flush = 1'b1;
    end
    @(negedge clk);
    bus.flush = 1'b0;
    e = exp_q.pop_back();
    chk("flush_run_idle", bus.busy, 0);
    chk("flush_run_hi", bus.hi, 32'h1234);
    chk("flush_run_lo", bus.lo, 32'h5678);
    repeat (LAT + 6) @(negedge clk);

    run_arith(3'd2, $urandom, $urandom, 1'b0, LAT);

    drive(3'd3, $urandom, 32'd3, 1'b0, e);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == 20) rst = 1'b1;
    end
    @(negedge clk);
    e = exp_q.pop_back();
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_done", bus.done, 0);
    chk("rst_mid_dbz", bus.div_by_zero, 0);
    chk("rst_mid_hi", bus.hi, 0);
    chk("rst_mid_lo", bus.lo, 0);
    model_hi = '0;
    model_lo = '0;
    rst = 1'b0;
    run_arith(3'd1, $urandom, $urandom, 1'b0, 0);

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 11);
      av  = pick();
      bv  = pick();
      if ($urandom_range(0, 7) == 0) bv = '0;
      if (sel < 8) begin
        run_arith(3'(sel % 4), av, bv, 1'b1, 0);
      end else begin
        drive(3'(sel - 4), av, bv, 1'b0, e);
        @(negedge clk);
        bus.start = 1'b0;
        chk("mt_busy", bus.busy, 0);
        chk("mt_hi", bus.hi, model_hi);
        chk("mt_lo", bus.lo, model_lo);
      end
    end

    repeat (5) @(negedge clk);
    chk("pending_results", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
